// File: rtl/xup_inv_share_arbiter.sv
// xup_inv_share_arbiter
// Round-robin sequencer that time-shares one external vector inverter among
// NREQ requesters. Each transaction grants one requester and registers its
// operand onto the inverter input. It holds that input for SETTLE clocks,
// captures the inverter output into y, and pulses ack/y_valid for one cycle.
module xup_inv_share_arbiter #(
    parameter int SIZE   = 4,
    parameter int NREQ   = 4,
    parameter int SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*SIZE-1:0]      a_flat,
    output logic [NREQ-1:0]           ack,
    output logic [SIZE-1:0]           y,
    output logic                      y_valid,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy,
    output logic [SIZE-1:0]           inv_a,
    input  logic [SIZE-1:0]           inv_y
);

    localparam int GW = $clog2(NREQ);

    generate
        if (SETTLE < 1 || SETTLE > 15) begin : g_settle_check
            $error("xup_inv_share_arbiter: SETTLE must be in 1..15");
        end
        if (NREQ < 2 || NREQ > 8) begin : g_nreq_check
            $error("xup_inv_share_arbiter: NREQ must be in 2..8");
        end
        if (SIZE < 1 || SIZE > 32) begin : g_size_check
            $error("xup_inv_share_arbiter: SIZE must be in 1..32");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   ptr_next;
    logic [3:0]      cnt;
    logic [3:0]      cnt_next;
    logic [GW-1:0]   grant_next;
    logic [SIZE-1:0] inv_a_next;
    logic [SIZE-1:0] y_next;
    logic [NREQ-1:0] ack_next;
    logic            y_valid_next;

    logic [SIZE-1:0] operand [NREQ];
    logic [GW-1:0]   sel;
    logic            found;
    logic [GW-1:0]   idx_v;
    int              idx;

    // Unpack the flat operand bus so it can be indexed by requester number.
    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_unpack
            assign operand[g] = a_flat[g*SIZE +: SIZE];
        end
    endgenerate

    assign busy = (state == DRIVE) || (state == DONE);

    // Round-robin search: first active request at or above the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        idx_v = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx   = (int'(ptr) + k) % NREQ;
            idx_v = idx[GW-1:0];
            if (!found && req[idx_v]) begin
                found = 1'b1;
                sel   = idx_v;
            end
        end
    end

    // Next-state and next-register values for the transaction sequencer.
    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        cnt_next     = cnt;
        grant_next   = grant_id;
        inv_a_next   = inv_a;
        y_next       = y;
        ack_next     = '0;
        y_valid_next = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_next = sel;
                    inv_a_next = operand[sel];
                    cnt_next   = 4'(SETTLE - 1);
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    y_next             = inv_y;
                    ack_next[grant_id] = 1'b1;
                    y_valid_next       = 1'b1;
                    state_next         = DONE;
                end
            end
            DONE: begin
                // Move the pointer past the requester just served so it gets lowest priority next.
                if (grant_id == GW'(NREQ - 1)) begin
                    ptr_next = '0;
                end else begin
                    ptr_next = grant_id + 1'b1;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction without an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            grant_id <= '0;
            inv_a    <= '0;
            y        <= '0;
            ack      <= '0;
            y_valid  <= 1'b0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            cnt      <= cnt_next;
            grant_id <= grant_next;
            inv_a    <= inv_a_next;
            y        <= y_next;
            ack      <= ack_next;
            y_valid  <= y_valid_next;
        end
    end

endmodule

// File: tb/tb_xup_inv_share_arbiter.sv
// Testbench for xup_inv_share_arbiter: three instances (SETTLE=1, 2, 3) with
// per-instance scoreboards of expected {grant id, result} popped on y_valid.
module tb_xup_inv_share_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         id;
        logic [3:0] y;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    int   vq1[$];
    int   last_v1 = 0;
    int   last_v3 = 0;

    // ---------------- DUT 1: SETTLE=1, combinational inverter
    logic        reset1 = 1'b1;
    logic [3:0]  req1 = '0;
    logic [15:0] a1 = '0;
    logic [3:0]  ack1;
    logic [3:0]  y1;
    logic        y_valid1;
    logic [1:0]  gid1;
    logic        busy1;
    logic [3:0]  inv_a1;
    logic [3:0]  inv_y1;
    assign inv_y1 = ~inv_a1;

    xup_inv_share_arbiter #(.SIZE(4), .NREQ(4), .SETTLE(1)) u_dut1 (
        .clk(clk), .reset(reset1), .req(req1), .a_flat(a1), .ack(ack1),
        .y(y1), .y_valid(y_valid1), .grant_id(gid1), .busy(busy1),
        .inv_a(inv_a1), .inv_y(inv_y1)
    );

    // ---------------- DUT 2: SETTLE=2, combinational inverter
    logic        reset2 = 1'b1;
    logic [3:0]  req2 = '0;
    logic [15:0] a2 = '0;
    logic [3:0]  ack2;
    logic [3:0]  y2;
    logic        y_valid2;
    logic [1:0]  gid2;
    logic        busy2;
    logic [3:0]  inv_a2;
    logic [3:0]  inv_y2;
    assign inv_y2 = ~inv_a2;

    xup_inv_share_arbiter #(.SIZE(4), .NREQ(4), .SETTLE(2)) u_dut2 (
        .clk(clk), .reset(reset2), .req(req2), .a_flat(a2), .ack(ack2),
        .y(y2), .y_valid(y_valid2), .grant_id(gid2), .busy(busy2),
        .inv_a(inv_a2), .inv_y(inv_y2)
    );

    // ---------------- DUT 3: SETTLE=3, inverter output lags input by 2 clocks
    logic        reset3 = 1'b1;
    logic [3:0]  req3 = '0;
    logic [15:0] a3 = '0;
    logic [3:0]  ack3;
    logic [3:0]  y3;
    logic        y_valid3;
    logic [1:0]  gid3;
    logic        busy3;
    logic [3:0]  inv_a3;
    logic [3:0]  inv_y3;
    logic [3:0]  dly1 = '0;
    logic [3:0]  dly2 = '0;
    always @(posedge clk) begin
        dly1 <= ~inv_a3;
        dly2 <= dly1;
    end
    assign inv_y3 = dly2;

    xup_inv_share_arbiter #(.SIZE(4), .NREQ(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .reset(reset3), .req(req3), .a_flat(a3), .ack(ack3),
        .y(y3), .y_valid(y_valid3), .grant_id(gid3), .busy(busy3),
        .inv_a(inv_a3), .inv_y(inv_y3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int qsize(input int w);
        if (w == 1) return q1.size();
        if (w == 2) return q2.size();
        return q3.size();
    endfunction

    task automatic wait_empty(input int w, input int budget);
        int n = 0;
        while (qsize(w) != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check($sformatf("drain_timeout_dut%0d", w), qsize(w), 0);
    endtask

    // Scoreboard monitors: compare each completion against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (y_valid1) begin
            last_v1 = cyc;
            vq1.push_back(cyc);
            if (q1.size() == 0) check("dut1_unexpected_valid", y_valid1, 0);
            else begin
                e = q1.pop_front();
                check("dut1_y", y1, e.y);
                check("dut1_gid", gid1, e.id);
                check("dut1_ack_onehot", ack1, 4'b0001 << e.id);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (y_valid2) begin
            if (q2.size() == 0) check("dut2_unexpected_valid", y_valid2, 0);
            else begin
                e = q2.pop_front();
                check("dut2_y", y2, e.y);
                check("dut2_gid", gid2, e.id);
                check("dut2_ack_onehot", ack2, 4'b0001 << e.id);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (y_valid3) begin
            last_v3 = cyc;
            if (q3.size() == 0) check("dut3_unexpected_valid", y_valid3, 0);
            else begin
                e = q3.pop_front();
                check("dut3_y", y3, e.y);
                check("dut3_gid", gid3, e.id);
                check("dut3_ack_onehot", ack3, 4'b0001 << e.id);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected end by 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        repeat (2) @(negedge clk);
        // Reset state
        check("rst_ack", ack1, 0);
        check("rst_y_valid", y_valid1, 0);
        check("rst_y", y1, 0);
        check("rst_inv_a", inv_a1, 0);
        check("rst_gid", gid1, 0);
        check("rst_busy", busy1, 0);
        reset1 = 1'b0;
        reset2 = 1'b0;
        reset3 = 1'b0;
        @(negedge clk);

        // Single request, SETTLE=1
        a1[3:0] = 4'b1010;
        req1 = 4'b0001;
        q1.push_back('{0, 4'b0101});
        @(negedge clk);
        g = cyc;
        check("t1_busy_drive", busy1, 1);
        check("t1_inv_a", inv_a1, 4'b1010);
        @(negedge clk);
        check("t1_busy_done", busy1, 1);
        req1 = 4'b0000;
        @(negedge clk);
        check("t1_busy_idle", busy1, 0);
        check("t1_ack_cleared", ack1, 0);
        check("t1_y_hold", y1, 4'b0101);
        check("t1_latency", last_v1 - g, 1);

        // All four requesting continuously
        reset1 = 1'b1;
        @(negedge clk);
        reset1 = 1'b0;
        a1 = {4'd3, 4'd2, 4'd1, 4'd0};
        vq1.delete();
        q1.push_back('{0, 4'hF});
        q1.push_back('{1, 4'hE});
        q1.push_back('{2, 4'hD});
        q1.push_back('{3, 4'hC});
        q1.push_back('{0, 4'hF});
        req1 = 4'b1111;
        wait_empty(1, 40);
        req1 = 4'b0000;
        check("t2_txn_count", vq1.size(), 5);
        for (int i = 0; i + 1 < vq1.size(); i++)
            check($sformatf("t2_spacing_%0d", i), vq1[i+1] - vq1[i], 3);
        repeat (3) @(negedge clk);

        // Requester 1 holds req through its ack while requester 3 is waiting
        reset1 = 1'b1;
        @(negedge clk);
        reset1 = 1'b0;
        a1 = {4'h9, 4'h0, 4'h5, 4'h0};
        q1.push_back('{1, 4'hA});
        q1.push_back('{3, 4'h6});
        q1.push_back('{1, 4'hA});
        req1 = 4'b1010;
        wait_empty(1, 40);
        req1 = 4'b0000;
        repeat (3) @(negedge clk);

        // SETTLE=3 with a lagging inverter: result must not be stale
        a3[11:8] = 4'h6;
        req3 = 4'b0100;
        q3.push_back('{2, 4'h9});
        @(negedge clk);
        g = cyc;
        check("t3_inv_a", inv_a3, 4'h6);
        repeat (3) @(negedge clk);
        req3 = 4'b0000;
        @(negedge clk);
        check("t3_latency", last_v3 - g, 3);
        check("t3_y", y3, 4'h9);
        repeat (2) @(negedge clk);

        // Reset asserted mid-DRIVE
        req3 = 4'b0100;
        @(negedge clk);
        check("t5_busy_before", busy3, 1);
        check("t5_gid_before", gid3, 2);
        #1 reset3 = 1'b1;
        #1;
        check("t5_rst_ack", ack3, 0);
        check("t5_rst_y_valid", y_valid3, 0);
        check("t5_rst_busy", busy3, 0);
        check("t5_rst_inv_a", inv_a3, 0);
        check("t5_rst_y", y3, 0);
        @(negedge clk);
        reset3 = 1'b0;
        a3[7:4] = 4'h2;
        req3 = 4'b0110;
        q3.push_back('{1, 4'hD});
        @(negedge clk);
        check("t5_grant_after_rst", gid3, 1);
        wait_empty(3, 40);
        req3 = 4'b0000;
        repeat (3) @(negedge clk);

        // Operand change after the grant edge, SETTLE=2
        a2[3:0] = 4'h3;
        req2 = 4'b0001;
        q2.push_back('{0, 4'hC});
        @(negedge clk);
        check("t6_inv_a_grant", inv_a2, 4'h3);
        a2[3:0] = 4'hC;
        @(negedge clk);
        check("t6_inv_a_drive", inv_a2, 4'h3);
        @(negedge clk);
        check("t6_inv_a_done", inv_a2, 4'h3);
        req2 = 4'b0000;
        @(negedge clk);
        check("t6_y", y2, 4'hC);
        repeat (3) @(negedge clk);

        check("final_q1_empty", q1.size(), 0);
        check("final_q2_empty", q2.size(), 0);
        check("final_q3_empty", q3.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
